cordic_iterative_core: RTL and testbench

- Parametrised successor of the fixed-shift, single-stage shift-accumulate block.
- One shared micro-rotation datapath is reused over ITER clock cycles under an FSM, with a runtime shift amount.
- Supports rotation and vectoring modes, uses arithmetic shifts, and has ready/valid handshakes on both sides.
- Sits between the angle/vector source and downstream sin/cos/magnitude consumers, replacing unrolled pipelines where area matters.

---
 rtl/cordic_pkg.sv | 68 ++++++
 rtl/cordic_micro_rotation.sv | 43 ++++
 rtl/cordic_iterative_core.sv | 146 ++++++++++++++
 tb/tb_cordic_iterative_core.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the iterative CORDIC core and its micro-rotation stage.
// Optional build macro used by the core: CORDIC_GAIN_COMP_EN.
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAIN = 2'd2,
        DONE = 2'd3
    } cordic_state_t;

    localparam logic MODE_ROT = 1'b0;   // drive z toward 0
    localparam logic MODE_VEC = 1'b1;   // drive y toward 0

    // 1/An scaled so that 2^31 represents 1.0 (round(0.6072529350 * 2^31)).
    localparam logic [31:0] KQ32 = 32'h4DBA76D4;

    // atan(2^-i)/pi * 2^31, rounded; z angle format puts pi at 2^31.
    function automatic logic [31:0] atan32(input logic [4:0] idx);
        logic [31:0] a;
        case (idx)
            5'd0:  a = 32'h2000_0000;
            5'd1:  a = 32'h12E4_051E;
            5'd2:  a = 32'h09FB_385B;
            5'd3:  a = 32'h0511_11D4;
            5'd4:  a = 32'h028B_0D43;
            5'd5:  a = 32'h0145_D7E1;
            5'd6:  a = 32'h00A2_F61E;
            5'd7:  a = 32'h0051_7C55;
            5'd8:  a = 32'h0028_BE53;
            5'd9:  a = 32'h0014_5F2F;
            5'd10: a = 32'h000A_2F98;
            5'd11: a = 32'h0005_17CC;
            5'd12: a = 32'h0002_8BE6;
            5'd13: a = 32'h0001_45F3;
            5'd14: a = 32'h0000_A2FA;
            5'd15: a = 32'h0000_517D;
            5'd16: a = 32'h0000_28BE;
            5'd17: a = 32'h0000_145F;
            5'd18: a = 32'h0000_0A30;
            5'd19: a = 32'h0000_0518;
            5'd20: a = 32'h0000_028C;
            5'd21: a = 32'h0000_0146;
            5'd22: a = 32'h0000_00A3;
            5'd23: a = 32'h0000_0051;
            5'd24: a = 32'h0000_0029;
            5'd25: a = 32'h0000_0014;
            5'd26: a = 32'h0000_000A;
            5'd27: a = 32'h0000_0005;
            5'd28: a = 32'h0000_0003;
            5'd29: a = 32'h0000_0001;
            5'd30: a = 32'h0000_0001;
            default: a = 32'h0000_0000;
        endcase
        return a;
    endfunction

    // Gain constant rescaled to a w-bit word with 2^(w-1) = 1.0, rounded to nearest.
    function automatic logic [31:0] kq_scaled(input int unsigned w);
        logic [31:0] k;
        if (w >= 32)
            k = KQ32;
        else
            k = (KQ32 + (32'd1 << (31 - w))) >> (32 - w);
        return k;
    endfunction

endpackage

// File: rtl/cordic_micro_rotation.sv
// One combinational CORDIC micro-rotation: shift-add on x/y and angle update on z.
// Stateless so the same stage can be replicated for an unrolled pipeline.
module cordic_micro_rotation
    import cordic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SW    = 5
) (
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] y,
    input  logic signed [WIDTH-1:0] z,
    input  logic        [SW-1:0]    shift,
    input  logic signed [WIDTH-1:0] atan_i,
    input  logic                    mode,
    output logic signed [WIDTH-1:0] x_next,
    output logic signed [WIDTH-1:0] y_next,
    output logic signed [WIDTH-1:0] z_next
);

    logic                    d_pos;
    logic signed [WIDTH-1:0] x_sh;
    logic signed [WIDTH-1:0] y_sh;

    // Direction pick and shift-add; zero z / zero y both rotate in the negative sense.
    always_comb begin
        x_sh = x >>> shift;
        y_sh = y >>> shift;
        if (mode == MODE_VEC)
            d_pos = y[WIDTH-1];
        else
            d_pos = !z[WIDTH-1] && (z != '0);
        if (d_pos) begin
            x_next = x - y_sh;
            y_next = y + x_sh;
            z_next = z - atan_i;
        end else begin
            x_next = x + y_sh;
            y_next = y - x_sh;
            z_next = z + atan_i;
        end
    end

endmodule

// File: rtl/cordic_iterative_core.sv
// Iterative CORDIC: a single micro-rotation stage reused for ITER cycles,
// rotation or vectoring mode, ready/valid on both sides.
// Optional build macro CORDIC_GAIN_COMP_EN adds a GAIN cycle that removes the
// CORDIC gain from x/y.
//
//  state | meaning
//  IDLE  | in_ready=1, waiting for operands
//  RUN   | one micro-rotation per cycle, i = 0 .. ITER-1
//  GAIN  | x,y scaled by 1/An (only with CORDIC_GAIN_COMP_EN)
//  DONE  | out_valid=1, result held until out_ready
module cordic_iterative_core
    import cordic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [WIDTH-1:0] in_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic [WIDTH-1:0] out_z
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] I_LAST = SW'(ITER - 1);

    cordic_state_t state_q, state_n;

    logic signed [WIDTH-1:0] x_q, y_q, z_q;
    logic signed [WIDTH-1:0] x_nx, y_nx, z_nx;
    logic        [SW-1:0]    i_q;
    logic                    mode_q;
    logic        [31:0]      atan_full;
    logic signed [WIDTH-1:0] atan_i;
    logic                    load;
    logic                    step;

    // Narrower words keep the top bits of the 32-bit angle table.
    assign atan_full = atan32(5'(i_q));
    assign atan_i    = WIDTH'(atan_full >> (32 - WIDTH));

    cordic_micro_rotation #(
        .WIDTH (WIDTH),
        .SW    (SW)
    ) u_rot (
        .x      (x_q),
        .y      (y_q),
        .z      (z_q),
        .shift  (i_q),
        .atan_i (atan_i),
        .mode   (mode_q),
        .x_next (x_nx),
        .y_next (y_nx),
        .z_next (z_nx)
    );

`ifdef CORDIC_GAIN_COMP_EN
    // KQ is 1/An with 2^(WIDTH-1) = 1.0; dropping the duplicated sign bit of the
    // product returns x/y to their input scale.
    localparam logic signed [WIDTH-1:0] KQ = WIDTH'(kq_scaled(WIDTH));

    logic signed [2*WIDTH-1:0] x_prod, y_prod;
    logic signed [WIDTH-1:0]   x_gain, y_gain;
    logic                      gain_step;

    assign x_prod = x_q * KQ;
    assign y_prod = y_q * KQ;
    assign x_gain = WIDTH'(x_prod >>> (WIDTH - 1));
    assign y_gain = WIDTH'(y_prod >>> (WIDTH - 1));
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_n;
    end

    // Next-state decode.
    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE: if (in_valid) state_n = RUN;
`ifdef CORDIC_GAIN_COMP_EN
            RUN:  if (i_q == I_LAST) state_n = GAIN;
`else
            RUN:  if (i_q == I_LAST) state_n = DONE;
`endif
            GAIN: state_n = DONE;
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State-decoded handshake and datapath enables.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        load      = (state_q == IDLE) && in_valid;
        step      = (state_q == RUN);
`ifdef CORDIC_GAIN_COMP_EN
        gain_step = (state_q == GAIN);
`endif
    end

    // Working registers: operand capture, one micro-rotation per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            i_q    <= '0;
            mode_q <= 1'b0;
        end else if (load) begin
            x_q    <= in_x;
            y_q    <= in_y;
            z_q    <= in_z;
            i_q    <= '0;
            mode_q <= in_mode;
        end else if (step) begin
            x_q <= x_nx;
            y_q <= y_nx;
            z_q <= z_nx;
            i_q <= i_q + SW'(1);
`ifdef CORDIC_GAIN_COMP_EN
        end else if (gain_step) begin
            x_q <= x_gain;
            y_q <= y_gain;
`endif
        end
    end

    assign out_x = x_q;
    assign out_y = y_q;
    assign out_z = z_q;

endmodule

// File: tb/tb_cordic_iterative_core.sv
// Directed bench for cordic_iterative_core (WIDTH=32, ITER=16): table of vectors
// with hand-computed approximate results plus a bit-exact reference model,
// followed by back-pressure and mid-run reset sequences.
module tb_cordic_iterative_core;

    localparam int WIDTH = 32;
    localparam int ITER  = 16;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT = ITER + 1;
`else
    localparam int LAT = ITER;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             in_mode;
    logic [WIDTH-1:0] in_x, in_y, in_z;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_x, out_y, out_z;

    always #5 clk = ~clk;

    cordic_iterative_core #(
        .WIDTH (WIDTH),
        .ITER  (ITER)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_z      (in_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_z     (out_z)
    );

    typedef struct {
        logic        mode;
        logic [31:0] x, y, z;
        logic [31:0] ex, ey, ez;
        int          tol_xy;
        int          tol_z;
    } vec_t;

    typedef struct {
        logic [31:0] x, y, z;
    } res_t;

    localparam logic [31:0] REF_ATAN [0:15] = '{
        32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D
    };

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs [6];

    task automatic check(input string name, input bit ok,
                         input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic bit near(input logic [31:0] a, input logic [31:0] e, input int tol);
        longint d;
        d = longint'($signed(a)) - longint'($signed(e));
        if (d < 0) d = -d;
        return d <= longint'(tol);
    endfunction

    function automatic res_t ref_model(input logic mode, input logic [31:0] x0,
                                       input logic [31:0] y0, input logic [31:0] z0);
        logic signed [31:0] x, y, z, xs, ys, a;
        longint p;
        bit dp;
        res_t r;
        x = x0; y = y0; z = z0;
        for (int i = 0; i < ITER; i++) begin
            xs = x >>> i;
            ys = y >>> i;
            a  = REF_ATAN[i];
            dp = mode ? (y < 0) : (z > 0);
            if (dp) begin
                x = x - ys; y = y + xs; z = z - a;
            end else begin
                x = x + ys; y = y - xs; z = z + a;
            end
        end
`ifdef CORDIC_GAIN_COMP_EN
        p = longint'(x) * 64'sd1304065748;
        x = 32'(p >>> 31);
        p = longint'(y) * 64'sd1304065748;
        y = 32'(p >>> 31);
`else
        p = 0;
`endif
        r.x = x; r.y = y; r.z = z + 32'(p & 0);
        return r;
    endfunction

    // Present operands, wait for acceptance, then count cycles to out_valid.
    task automatic start_op(input logic mode, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] z, output int lat);
        int g;
        in_mode = mode; in_x = x; in_y = y; in_z = z; in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 50) begin
            @(posedge clk); #1; g++;
        end
        check("accept_in_ready", in_ready, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_x = 32'hDEAD_BEEF; in_y = 32'h5555_AAAA; in_z = 32'h7FFF_0001; in_mode = ~mode;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_consume_in_ready", in_ready, {31'd0, in_ready}, 32'd1);
        check("post_consume_out_valid", !out_valid, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic exact_check(input string tag, input res_t m);
        check({tag, "_x_exact"}, out_x == m.x, out_x, m.x);
        check({tag, "_y_exact"}, out_y == m.y, out_y, m.y);
        check({tag, "_z_exact"}, out_z == m.z, out_z, m.z);
    endtask

    initial begin
        int   lat;
        res_t m;
        res_t held;
        bit   ok;

`ifdef CORDIC_GAIN_COMP_EN
        vecs[0] = '{1'b0, 32'h4000_0000, 32'h0, 32'h2000_0000, 32'h2D41_3CCC, 32'h2D41_3CCC, 32'h0, 32768, 131072};
        vecs[1] = '{1'b1, 32'h1000_0000, 32'h1000_0000, 32'h0, 32'd379625062, 32'h0, 32'h2000_0000, 32768, 131072};
        vecs[2] = '{1'b0, 32'h4000_0000, 32'h0, 32'h0, 32'h4000_0000, 32'h0, 32'h0, 65536, 131072};
        vecs[3] = '{1'b1, 32'h2000_0000, 32'h0, 32'h0, 32'h2000_0000, 32'h0, 32'h0, 65536, 131072};
        vecs[4] = '{1'b0, 32'hE000_0000, 32'h0, 32'h2000_0000, -32'sd379625062, -32'sd379625062, 32'h0, 65536, 131072};
        vecs[5] = '{1'b1, 32'h2000_0000, 32'hE000_0000, 32'h0, 32'd759250125, 32'h0, 32'hE000_0000, 65536, 131072};
`else
        // out_x/out_y include An ~= 1.6467603 (e.g. vec1: An*sqrt(2)*2^28).
        vecs[0] = '{1'b0, 32'h26DD_3B6A, 32'h0, 32'h2000_0000, 32'h2D41_3CCC, 32'h2D41_3CCC, 32'h0, 32768, 131072};
        vecs[1] = '{1'b1, 32'h1000_0000, 32'h1000_0000, 32'h0, 32'd625151465, 32'h0, 32'h2000_0000, 32768, 131072};
        vecs[2] = '{1'b0, 32'h26DD_3B6A, 32'h0, 32'h0, 32'h4000_0000, 32'h0, 32'h0, 65536, 131072};
        vecs[3] = '{1'b1, 32'h2000_0000, 32'h0, 32'h0, 32'd884097704, 32'h0, 32'h0, 65536, 131072};
        vecs[4] = '{1'b0, 32'hE000_0000, 32'h0, 32'h2000_0000, -32'sd625151465, -32'sd625151465, 32'h0, 65536, 131072};
        vecs[5] = '{1'b1, 32'h2000_0000, 32'hE000_0000, 32'h0, 32'd1250302930, 32'h0, 32'hE000_0000, 65536, 131072};
`endif

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_mode = 1'b0; in_x = '0; in_y = '0; in_z = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("reset_in_ready",  in_ready == 1'b1,  {31'd0, in_ready},  32'd1);
        check("reset_out_valid", out_valid == 1'b0, {31'd0, out_valid}, 32'd0);
        check("reset_out_x", out_x == '0, out_x, 32'd0);
        check("reset_out_y", out_y == '0, out_y, 32'd0);
        check("reset_out_z", out_z == '0, out_z, 32'd0);

        for (int v = 0; v < 6; v++) begin
            start_op(vecs[v].mode, vecs[v].x, vecs[v].y, vecs[v].z, lat);
            check($sformatf("v%0d_latency", v), lat == LAT, 32'(lat), 32'(LAT));
            check($sformatf("v%0d_x_near", v), near(out_x, vecs[v].ex, vecs[v].tol_xy), out_x, vecs[v].ex);
            check($sformatf("v%0d_y_near", v), near(out_y, vecs[v].ey, vecs[v].tol_xy), out_y, vecs[v].ey);
            check($sformatf("v%0d_z_near", v), near(out_z, vecs[v].ez, vecs[v].tol_z),  out_z, vecs[v].ez);
            m = ref_model(vecs[v].mode, vecs[v].x, vecs[v].y, vecs[v].z);
            exact_check($sformatf("v%0d", v), m);
            finish_op();
        end

        // Back-pressure: result must hold and no new operands may be taken.
        start_op(vecs[1].mode, vecs[1].x, vecs[1].y, vecs[1].z, lat);
        check("bp_latency", lat == LAT, 32'(lat), 32'(LAT));
        held.x = out_x; held.y = out_y; held.z = out_z;
        in_valid = 1'b1; in_mode = 1'b0;
        in_x = 32'h0123_4567; in_y = 32'h7654_3210; in_z = 32'h1000_0000;
        ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (!out_valid || in_ready || out_x != held.x || out_y != held.y || out_z != held.z)
                ok = 1'b0;
        end
        check("bp_hold_stable", ok, out_x, held.x);
        m = ref_model(vecs[1].mode, vecs[1].x, vecs[1].y, vecs[1].z);
        exact_check("bp", m);
        in_valid = 1'b0;
        finish_op();

        start_op(vecs[0].mode, vecs[0].x, vecs[0].y, vecs[0].z, lat);
        check("bp_next_latency", lat == LAT, 32'(lat), 32'(LAT));
        m = ref_model(vecs[0].mode, vecs[0].x, vecs[0].y, vecs[0].z);
        exact_check("bp_next", m);
        finish_op();

        // Reset during iteration 5 aborts cleanly.
        in_mode = vecs[0].mode; in_x = vecs[0].x; in_y = vecs[0].y; in_z = vecs[0].z;
        in_valid = 1'b1;
        check("rr_in_ready", in_ready, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rr_out_valid", out_valid == 1'b0, {31'd0, out_valid}, 32'd0);
        check("rr_in_ready_after", in_ready == 1'b1, {31'd0, in_ready}, 32'd1);
        check("rr_out_x", out_x == '0, out_x, 32'd0);
        check("rr_out_y", out_y == '0, out_y, 32'd0);
        check("rr_out_z", out_z == '0, out_z, 32'd0);
        ok = 1'b1;
        for (int c = 0; c < ITER + 4; c++) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) ok = 1'b0;
        end
        check("rr_no_partial_result", ok, {31'd0, out_valid}, 32'd0);

        start_op(vecs[4].mode, vecs[4].x, vecs[4].y, vecs[4].z, lat);
        check("rr_fresh_latency", lat == LAT, 32'(lat), 32'(LAT));
        m = ref_model(vecs[4].mode, vecs[4].x, vecs[4].y, vecs[4].z);
        exact_check("rr_fresh", m);
        finish_op();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

endmodule
